// File: rtl/instr_encoder.sv
// RV32I field packer: encodes instruction field bundles into 32-bit words,
// queues them in a small FIFO and writes them to sequential memory addresses.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [19:0]       imm_20,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              err,
  output logic [15:0]       words_written
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       words_reg;
  logic [31:0]       hold_reg;
  logic              err_reg;

  logic [31:0] enc_word;
  logic        supported;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] head_word;

  always_comb begin
    enc_word  = '0;
    supported = 1'b1;
    case (opcode)
      7'b0110011: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      7'b0010011, 7'b0000011, 7'b1100111:
        enc_word = {imm_20[11:0], rs1, funct3, rd, opcode};
      7'b0100011: enc_word = {imm_20[11:5], rs2, rs1, funct3, imm_20[4:0], opcode};
      7'b1100011: enc_word = {imm_20[11], imm_20[9:4], rs2, rs1, funct3,
                              imm_20[3:0], imm_20[10], opcode};
      7'b1101111: enc_word = {imm_20[19], imm_20[9:0], imm_20[10], imm_20[18:11],
                              rd, opcode};
      7'b0110111: enc_word = {imm_20, rd, opcode};
      default:    supported = 1'b0;
    endcase
  end

  assign full      = (count_reg == CNT_W'(DEPTH));
  assign empty     = (count_reg == '0);
  assign in_ready  = !full;
  assign accept    = in_valid && !full && !clr;
  assign push      = accept && supported;
  // clr wins over the write handshake: no pop, no address advance, no count
  assign pop       = !empty && mem_ack && !clr;
  assign head_word = fifo_mem[rd_ptr_reg];

  assign mem_wen       = !empty;
  assign mem_addr      = addr_reg;
  assign mem_wdata     = empty ? hold_reg : head_word;
  assign err           = err_reg;
  assign words_written = words_reg;

  // Storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      addr_reg   <= BASE_ADDR;
      words_reg  <= '0;
      hold_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (!empty) begin
        hold_reg <= head_word;
      end
      err_reg <= accept && !supported;
      if (clr) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        addr_reg   <= BASE_ADDR;
        words_reg  <= '0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          addr_reg   <= addr_reg + ADDR_W'(4);
          if (words_reg != 16'hFFFF) begin
            words_reg <= words_reg + 16'd1;
          end
        end
        if (push && !pop) begin
          count_reg <= count_reg + CNT_W'(1);
        end else if (pop && !push) begin
          count_reg <= count_reg - CNT_W'(1);
        end
      end
    end
  end

endmodule
